slave_mem_port: RTL and testbench
=================================

# slave_mem_port

Word-addressed memory slave that sits directly downstream of `router_top` and terminates one router slave channel on the master–slave bus. It accepts a held request, inserts a configurable number of wait states, performs the read or byte-masked write against a local array, and returns a single-cycle `ack`. Multiple instances at distinct `BASE_ADDR` values form the slave side of the router test system.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width; must be a multiple of 8.
- `ADDR_WIDTH`, 32: byte address width.
- `MEM_DEPTH`, 256: number of words; must be a power of two.
- `BASE_ADDR`, 0: first byte address decoded by this slave; must be word-aligned.
- `WAIT_STATES`, 2: cycles inserted between request capture and `ack`; range 0–15.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: request valid; the master holds it until `ack`.
- `we`, in, 1: 1 = write, 0 = read.
- `addr`, in, `ADDR_WIDTH`: byte address.
- `be`, in, `DATA_WIDTH/8`: byte enables for writes; ignored on reads.
- `wdata`, in, `DATA_WIDTH`: write data.
- `rdata`, out, `DATA_WIDTH`: read data; valid in the `ack` cycle.
- `ack`, out, 1: one-cycle completion pulse.
- `err`, out, 1: only present with `SLAVE_PORT_ERR_EN`; out-of-range flag, valid with `ack`.

## Operation
- FSM states:
  - `IDLE`: moves to `WAIT` when `req` is high. On that edge it captures `we`, `addr`, `be`, `wdata` and loads the wait counter with `WAIT_STATES`.
  - `WAIT`: decrements the counter. When the counter is 0, the access executes on that edge and the FSM moves to `ACK`. With `WAIT_STATES` = 0, `WAIT` lasts one cycle.
  - `ACK`: `ack` = 1 for exactly one cycle, then the FSM returns to `IDLE` unconditionally.
- Address decode:
  - In range when `BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH` (4 = bytes per word at the default width; in general the word size is `DATA_WIDTH/8`).
  - Word index = `(addr - BASE_ADDR) >> log2(DATA_WIDTH/8)`.
  - Low address bits are ignored, so misaligned addresses are truncated.
- Write: each byte lane i is updated only where `be[i]` = 1. `rdata` is driven to 0 during a write ack.
- Read: `rdata` is registered from the array on the execute edge and held until the next execute edge.
- Out-of-range access without the macro: writes are dropped, reads return 0, and `ack` is still given.
- Inputs are sampled only in `IDLE`. Changes to `req` or the payload during `WAIT` or `ACK` have no effect.
- If `req` is still high in the cycle after `ack`, it is a new request and is captured on that edge.

## Timing
- Reset values: `ack` = 0, `rdata` = 0, `err` = 0, FSM = `IDLE`, counter = 0. Array contents are not reset and are undefined until written.
- Latency: with `req` captured at edge N, `ack` is high during the cycle following edge N+1+`WAIT_STATES`, i.e. `WAIT_STATES`+2 cycles after capture.
- Back-to-back throughput: one access per `WAIT_STATES`+3 cycles.
- Reset asserted mid-operation: the FSM returns to `IDLE` immediately. A write whose execute edge has not yet occurred is not performed. No `ack` is issued for the aborted request.
- `ack` never stays high for two consecutive cycles.

## Configuration
- Macro: `SLAVE_PORT_ERR_EN`.
- Defined: the `err` port exists. An out-of-range access asserts `err` = 1 in the `ack` cycle, returns `rdata` = 0, and suppresses the write. `err` = 0 at all other times.
- Undefined: there is no `err` port, and out-of-range accesses complete silently as described in Operation.

## Structure
- Package `slave_port_pkg` contains:
  - the state enum (`IDLE`, `WAIT`, `ACK`);
  - the wait-counter width constant (4);
  - a function that computes the in-range flag and word index from `addr`, `BASE_ADDR` and `MEM_DEPTH`.
- Sub-module `slave_port_mem`: synchronous single-port array with byte-lane write enables and registered read, parameterised by `DATA_WIDTH` and `MEM_DEPTH`.
- `slave_mem_port` itself holds the FSM, capture registers, decode and `ack`/`err` generation.

## Test plan
- Reset held for 3 cycles, then released with no traffic: `ack` = 0 and `rdata` = 0 throughout.
- Write `0xDEADBEEF` to `0x10` with `be` = `0xF`, then read `0x10`: read returns `0xDEADBEEF`, and `ack` comes 4 cycles after each capture (`WAIT_STATES` = 2).
- Write `0x11223344` with `be` = `0x5` over a word holding `0xAABBCCDD`: readback is `0xAA22CC44`.
- `req` held high across two accesses: two `ack` pulses 5 cycles apart, with `ack` low in between.
- Read `0x400` with `MEM_DEPTH` = 256 and `BASE_ADDR` = 0 (out of range): `rdata` = 0 and `ack` is given. With `SLAVE_PORT_ERR_EN`, `err` = 1 in the `ack` cycle.
- Write `0x55` to `0x8`, with reset pulsed one cycle after capture: no `ack`, and the word at `0x8` keeps its prior value.

Source files
------------

// File: rtl/slave_port_pkg.sv
// rtl/slave_port_pkg.sv - shared types, constants and address decode for slave_mem_port
package slave_port_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        in_range;
    logic [31:0] idx;
  } decode_t;

  // Word offset is compared before truncation so far-away addresses cannot alias into the array.
  function automatic decode_t decode_addr(input logic [63:0] addr, input logic [63:0] base,
                                          input logic [31:0] depth, input int lg);
    logic [63:0] word;
    decode_t d;
    word = (addr - base) >> lg;
    d.in_range = (addr >= base) && (word < {32'd0, depth});
    d.idx = word[31:0];
    return d;
  endfunction

endpackage

// File: rtl/slave_port_mem.sv
// rtl/slave_port_mem.sv - single-port word array with byte-lane writes and registered read
module slave_port_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic                    zero,
  input  logic [IW-1:0]           idx,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read port holds its value between accesses; writes and rejected reads return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (en) rdata <= zero ? '0 : mem[idx];
  end

endmodule

// File: rtl/slave_mem_port.sv
// rtl/slave_mem_port.sv - wait-stated memory slave; SLAVE_PORT_ERR_EN adds the err port
module slave_mem_port
  import slave_port_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ack
`ifdef SLAVE_PORT_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int LG = (BW > 1) ? $clog2(BW) : 0;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic                cap_we, cap_ok;
  logic [IW-1:0]       cap_idx;
  logic [BW-1:0]       cap_be;
  logic [DATA_WIDTH-1:0] cap_wdata;
  decode_t             dec;
  logic                exec;
  logic                oor_ack;

  assign dec = decode_addr(64'(addr), 64'(BASE_ADDR), 32'(MEM_DEPTH), LG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack     = (state == ACK);
    exec    = (state == WAIT) && (cnt == '0);
    oor_ack = (state == ACK) && !cap_ok;
  end

`ifdef SLAVE_PORT_ERR_EN
  assign err = oor_ack;
`else
  logic unused_oor;
  assign unused_oor = oor_ack;
`endif

  // Payload is latched only on the IDLE->WAIT edge, so later input changes are invisible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_ok    <= 1'b0;
      cap_idx   <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && req) begin
      cnt       <= CNT_W'(WAIT_STATES);
      cap_we    <= we;
      cap_ok    <= dec.in_range;
      cap_idx   <= dec.idx[IW-1:0];
      cap_be    <= be;
      cap_wdata <= wdata;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  slave_port_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IW        (IW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .en   (exec),
    .we   (cap_we && cap_ok),
    .zero (cap_we || !cap_ok),
    .idx  (cap_idx),
    .be   (cap_be),
    .wdata(cap_wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_slave_mem_port.sv
// tb/tb_slave_mem_port.sv - randomized self-checking bench for slave_mem_port
module tb_slave_mem_port;

  localparam int      WS    = 2;
  localparam int      DEPTH = 256;
  localparam longint  BASE  = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
`ifdef SLAVE_PORT_ERR_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  slave_mem_port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
    .BASE_ADDR(32'(BASE)), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .ack(ack)
`ifdef SLAVE_PORT_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request is taken when the slave is free, completes WS+1 edges later,
  // and the slave is free again WS+3 edges after capture.
  logic [31:0] mmem [DEPTH];
  int          cyc = 0, free_at = 0, exec_at = 0;
  bit          pend_v = 0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  bit          exp_ack = 0, exp_err = 0;
  logic [31:0] exp_rdata = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pend_v = 0; exp_ack = 0; exp_err = 0; exp_rdata = '0; free_at = cyc;
      end else begin
        cyc++;
        exp_ack = 0; exp_err = 0;
        if (pend_v && cyc == exec_at) begin
          longint a;
          bit     inr;
          int     w;
          a = longint'(p_addr);
          inr = (a >= BASE) && (a - BASE < 4 * DEPTH);
          w = int'((a - BASE) / 4);
          pend_v = 0; exp_ack = 1; exp_err = !inr;
          if (p_we) begin
            exp_rdata = '0;
            if (inr) for (int i = 0; i < 4; i++)
              if (p_be[i]) mmem[w][8*i +: 8] = p_wdata[8*i +: 8];
          end else begin
            exp_rdata = inr ? mmem[w] : 32'd0;
          end
        end
        if (req && cyc >= free_at) begin
          pend_v = 1; p_we = we; p_addr = addr; p_be = be; p_wdata = wdata;
          exec_at = cyc + WS + 1; free_at = cyc + WS + 3;
        end
      end
    end
  end

  logic prev_ack = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      check("ack", 64'(ack), 64'(exp_ack));
      check("rdata", 64'(rdata), 64'(exp_rdata));
`ifdef SLAVE_PORT_ERR_EN
      check("err", 64'(err), 64'(exp_err));
`endif
      check("ack_pulse", 64'(ack && prev_ack), 64'd0);
      prev_ack = ack;
    end
  end

  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
    bit got = 0;
    @(posedge clk); #2;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    lat = 0; rd = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); lat++;
      #2; we = 1'($urandom); addr = $urandom; be = 4'($urandom); wdata = $urandom;
      @(negedge clk);
      if (ack) begin got = 1; rd = rdata; end
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #2; req = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat, gap, first, nack;

  initial begin
    repeat (3) @(posedge clk);
    #2; rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_ack", 64'(ack), 64'd0);
      check("idle_rdata", 64'(rdata), 64'd0);
    end

    for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), 4'hF, $urandom, rd, lat);

    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
    check("wr_latency", 64'(lat), 64'd4);
    check("wr_rdata_zero", 64'(rd), 64'd0);
    access(1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    check("rd_latency", 64'(lat), 64'd4);
    check("rd_deadbeef", 64'(rd), 64'hDEADBEEF);
    access(1'b0, 32'h12, 4'h0, 32'h0, rd, lat);
    check("rd_misaligned", 64'(rd), 64'hDEADBEEF);

    access(1'b1, 32'h20, 4'hF, 32'hAABBCCDD, rd, lat);
    access(1'b1, 32'h20, 4'h5, 32'h11223344, rd, lat);
    access(1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    check("rd_bytemask", 64'(rd), 64'hAA22CC44);

    access(1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D, rd, lat);
    access(1'b1, 32'h404, 4'hF, 32'h0BADBAD0, rd, lat);
    access(1'b0, 32'h3FC, 4'hF, 32'h0, rd, lat);
    check("rd_top_word", 64'(rd), 64'hCAFEF00D);
    access(1'b0, 32'h400, 4'hF, 32'h0, rd, lat);
    check("rd_oor_zero", 64'(rd), 64'd0);
    check("oor_latency", 64'(lat), 64'd4);

    // Held request: second access is captured the cycle after the first ack.
    @(posedge clk); #2;
    req = 1'b1; we = 1'b0; addr = 32'h20; be = 4'hF;
    first = -1; gap = -1; nack = 0;
    for (int k = 0; k < 40 && nack < 2; k++) begin
      @(negedge clk);
      if (ack) begin
        if (nack == 0) first = k; else gap = k - first;
        nack++;
      end
    end
    @(posedge clk); #2; req = 1'b0;
    check("b2b_gap", 64'(gap), 64'd5);

    access(1'b1, 32'h8, 4'hF, 32'h12345678, rd, lat);
    @(posedge clk); #2;
    req = 1'b1; we = 1'b1; addr = 32'h8; be = 4'hF; wdata = 32'h55;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    nack = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack) nack++;
    end
    check("abort_no_ack", 64'(nack), 64'd0);
    access(1'b0, 32'h8, 4'hF, 32'h0, rd, lat);
    check("abort_kept", 64'(rd), 64'h12345678);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) a = 32'h400 + $urandom_range(0, 32'h3FF);
      else a = 32'($urandom_range(0, 32'h3FF));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      access(1'($urandom), a, 4'($urandom), $urandom, rd, lat);
      check("rand_latency", 64'(lat), 64'd4);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
